// File: rtl/t_ff_pkg.sv
// Shared defaults and the next-state rule for the T flip-flop bank.
// Pure definitions; no state.
package t_ff_pkg;

    localparam int T_FF_DEF_WIDTH = 1;

    function automatic logic t_next(input logic q, input logic t, input logic en);
        return en ? (q ^ t) : q;
    endfunction

endpackage

// File: rtl/t_ff_if.sv
// Bundle of the T flip-flop bank's data signals for benches and wrappers.
// No logic; clk/rst stay outside the bundle.
interface t_ff_if
    import t_ff_pkg::*;
#(
    parameter int WIDTH = T_FF_DEF_WIDTH
);
    logic [WIDTH-1:0] T;
    logic             enable;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;

    modport master (output T, output enable, input q, input qbar);
    modport slave  (input T, input enable, output q, output qbar);
endinterface

// File: rtl/t_ff_bit.sv
// Single T flip-flop bit with enable and synchronous reset to rst_val.
// One-cycle latency; always accepts input, no backpressure.
module t_ff_bit
    import t_ff_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic t,
    input  logic en,
    input  logic rst_val,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= rst_val;
        end else begin
            q <= t_next(q, t, en);
        end
    end

endmodule

// File: rtl/t_ff.sv
// Bank of WIDTH independent T flip-flops sharing enable and reset; qbar = ~q.
// One-cycle latency from T/enable/rst to q; no backpressure.
module t_ff
    import t_ff_pkg::*;
#(
    parameter int               WIDTH       = T_FF_DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic [WIDTH-1:0] T,
    input  logic             rst,
    input  logic             clk,
    input  logic             enable,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar
);

    // Port order is positional-compatible with existing instantiations.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        t_ff_bit u_bit (
            .clk     (clk),
            .rst     (rst),
            .t       (T[i]),
            .en      (enable),
            .rst_val (RESET_VALUE[i]),
            .q       (q[i])
        );
    end

    assign qbar = ~q;

endmodule

// File: tb/tb_t_ff.sv
// Directed bench for t_ff at WIDTH=1 and WIDTH=4, scoreboard of expected q.
module tb_t_ff;
    import t_ff_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    t_ff_if #(.WIDTH(1)) bus1 ();
    t_ff_if #(.WIDTH(4)) bus4 ();

    t_ff u_dut1 (
        .T      (bus1.T),
        .rst    (rst),
        .clk    (clk),
        .enable (bus1.enable),
        .q      (bus1.q),
        .qbar   (bus1.qbar)
    );

    t_ff #(.WIDTH(4), .RESET_VALUE(4'b0000)) u_dut4 (
        .T      (bus4.T),
        .rst    (rst),
        .clk    (clk),
        .enable (bus4.enable),
        .q      (bus4.q),
        .qbar   (bus4.qbar)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic       exp_q1_q[$];
    logic [3:0] exp_q4_q[$];
    logic       m1;
    logic [3:0] m4;

    task automatic check1(input string tag, input logic got, input logic exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic check4(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Drive one cycle on both DUTs, push the model's result, then pop and compare after the edge.
    task automatic step(input string tag, input logic r, input logic en,
                        input logic t1, input logic [3:0] t4);
        logic       e1;
        logic [3:0] e4;
        @(negedge clk);
        rst         = r;
        bus1.enable = en;
        bus1.T      = t1;
        bus4.enable = en;
        bus4.T      = t4;
        m1 = r ? 1'b0  : (en ? (m1 ^ t1) : m1);
        m4 = r ? 4'b0000 : (en ? (m4 ^ t4) : m4);
        exp_q1_q.push_back(m1);
        exp_q4_q.push_back(m4);
        @(posedge clk);
        #1;
        if (exp_q1_q.size() == 0 || exp_q4_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s scoreboard empty got=%0d exp=1", tag, exp_q1_q.size());
        end else begin
            e1 = exp_q1_q.pop_front();
            e4 = exp_q4_q.pop_front();
            check1({tag, ".q1"},    bus1.q,    e1);
            check1({tag, ".qbar1"}, bus1.qbar, ~e1);
            check4({tag, ".q4"},    bus4.q,    e4);
            check4({tag, ".qbar4"}, bus4.qbar, ~e4);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        m1    = 1'bx;
        m4    = 4'bxxxx;
        rst   = 1'b0;
        bus1.T = 1'b0; bus1.enable = 1'b0;
        bus4.T = 4'b0; bus4.enable = 1'b0;

        // Reset beats T=1, enable=1.
        step("reset",   1'b1, 1'b1, 1'b1, 4'b1111);
        check1("reset_const_q1", bus1.q, 1'b0);
        check1("reset_const_qbar1", bus1.qbar, 1'b1);

        // Toggle: 1,0,1,0.
        step("tog0",    1'b0, 1'b1, 1'b1, 4'b0001);
        check1("tog0_const", bus1.q, 1'b1);
        step("tog1",    1'b0, 1'b1, 1'b1, 4'b0011);
        check1("tog1_const", bus1.q, 1'b0);
        step("tog2",    1'b0, 1'b1, 1'b1, 4'b0111);
        step("tog3",    1'b0, 1'b1, 1'b1, 4'b1111);
        check1("tog3_const", bus1.q, 1'b0);

        // Hold via T=0 from q=1.
        step("to1",     1'b0, 1'b1, 1'b1, 4'b1000);
        for (int i = 0; i < 3; i++) step("hold_t", 1'b0, 1'b1, 1'b0, 4'b0000);
        check1("hold_t_const", bus1.q, 1'b1);

        // Hold via enable=0 from q=0, then release.
        step("to0",     1'b0, 1'b1, 1'b1, 4'b0100);
        for (int i = 0; i < 3; i++) step("hold_en", 1'b0, 1'b0, 1'b1, 4'b1111);
        check1("hold_en_const", bus1.q, 1'b0);
        step("en_on",   1'b0, 1'b1, 1'b1, 4'b0010);
        check1("en_on_const", bus1.q, 1'b1);

        // No asynchronous path: changing rst/T between edges leaves q alone.
        @(negedge clk);
        rst = 1'b1; bus1.T = 1'b1; bus1.enable = 1'b1;
        #2;
        check1("no_async", bus1.q, 1'b1);

        // Reset mid-operation, then resume from 0.
        step("rst_mid", 1'b1, 1'b1, 1'b1, 4'b1111);
        step("resume",  1'b0, 1'b1, 1'b1, 4'b0000);
        check1("resume_const", bus1.q, 1'b1);

        // WIDTH=4 directed patterns from zero.
        step("w4_rst",  1'b1, 1'b1, 1'b0, 4'b0000);
        step("w4_a",    1'b0, 1'b1, 1'b0, 4'b1010);
        check4("w4_a_const", bus4.q, 4'b1010);
        step("w4_b",    1'b0, 1'b1, 1'b0, 4'b0110);
        check4("w4_b_const", bus4.q, 4'b1100);
        check4("w4_b_qbar_const", bus4.qbar, 4'b0011);

        // Short random run against the model.
        for (int i = 0; i < 40; i++) begin
            step("rand", ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
